// File: rtl/map_sst_seq.sv
// map_sst_seq -- save-state sequencer for mapper register files on the SSTBus.
//
// Walks sst register addresses 0..REG_CNT-1 after a start request.
//   save (dir=0): sets sst_addr, waits SETTLE cycles, samples sst_di and
//                 offers the byte to the host on dat_o with a valid/ready handshake.
//   load (dir=1): takes a host byte on dat_i, drives sst_addr/sst_dato/sst_we_reg,
//                 and pulses map_m2 high for M2_HI cycles. The mapper commits the
//                 write on the falling edge of map_m2.
// Owns sst_act for the whole transfer. abort cancels a transfer at any point.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   start, dir, abort               transfer control (start is sampled only in IDLE)
//   busy, done, aborted             status outputs (done and aborted are 1-cycle pulses)
//   dat_o, dat_o_vld, dat_o_rdy     save stream to the host
//   dat_i, dat_i_vld, dat_i_rdy     load stream from the host
//   sst_act, sst_addr, sst_dato,
//   sst_we_reg, sst_di              mapper save-state port
//   map_m2                          m2 substitute used for load commits
module map_sst_seq #(
  parameter int unsigned REG_CNT = 64,
  parameter int unsigned SETTLE  = 2,
  parameter int unsigned M2_HI   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dir,
  input  logic       abort,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic [7:0] dat_o,
  output logic       dat_o_vld,
  input  logic       dat_o_rdy,
  input  logic [7:0] dat_i,
  input  logic       dat_i_vld,
  output logic       dat_i_rdy,
  output logic       sst_act,
  output logic [7:0] sst_addr,
  output logic [7:0] sst_dato,
  output logic       sst_we_reg,
  input  logic [7:0] sst_di,
  output logic       map_m2
);

  typedef enum logic [2:0] {
    IDLE, RD_SET, RD_OUT, WR_GET, WR_HI, WR_LO, FIN
  } state_t;

  localparam logic [7:0] LAST_IDX    = 8'(REG_CNT - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [3:0] M2_LAST     = 4'(M2_HI - 1);

  state_t     state_q;
  logic [7:0] idx_q;
  logic [3:0] cnt_q;
  logic       busy_q, done_q, aborted_q;
  logic [7:0] dat_o_q;
  logic       dat_o_vld_q, dat_i_rdy_q;
  logic       sst_act_q, sst_we_reg_q, map_m2_q;
  logic [7:0] sst_addr_q, sst_dato_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      dat_o_q      <= '0;
      dat_o_vld_q  <= 1'b0;
      dat_i_rdy_q  <= 1'b0;
      sst_act_q    <= 1'b0;
      sst_addr_q   <= '0;
      sst_dato_q   <= '0;
      sst_we_reg_q <= 1'b0;
      map_m2_q     <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      if (state_q != IDLE && abort) begin
        // Dropping map_m2 together with sst_we_reg means the mapper sees the
        // falling edge with the write enable already low, so nothing commits.
        state_q      <= IDLE;
        cnt_q        <= '0;
        busy_q       <= 1'b0;
        sst_act_q    <= 1'b0;
        sst_we_reg_q <= 1'b0;
        map_m2_q     <= 1'b0;
        dat_o_vld_q  <= 1'b0;
        dat_i_rdy_q  <= 1'b0;
        aborted_q    <= 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              idx_q     <= '0;
              cnt_q     <= '0;
              busy_q    <= 1'b1;
              sst_act_q <= 1'b1;
              if (dir) begin
                dat_i_rdy_q <= 1'b1;
                state_q     <= WR_GET;
              end else begin
                sst_addr_q <= '0;
                state_q    <= RD_SET;
              end
            end
          end
          RD_SET: begin
            if (cnt_q == SETTLE_LAST) begin
              cnt_q       <= '0;
              dat_o_q     <= sst_di;
              dat_o_vld_q <= 1'b1;
              state_q     <= RD_OUT;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          RD_OUT: begin
            if (dat_o_rdy) begin
              dat_o_vld_q <= 1'b0;
              if (idx_q == LAST_IDX) begin
                state_q <= FIN;
              end else begin
                idx_q      <= idx_q + 8'd1;
                sst_addr_q <= idx_q + 8'd1;
                state_q    <= RD_SET;
              end
            end
          end
          WR_GET: begin
            if (dat_i_vld) begin
              sst_dato_q   <= dat_i;
              sst_addr_q   <= idx_q;
              sst_we_reg_q <= 1'b1;
              map_m2_q     <= 1'b1;
              dat_i_rdy_q  <= 1'b0;
              cnt_q        <= '0;
              state_q      <= WR_HI;
            end
          end
          WR_HI: begin
            if (cnt_q == M2_LAST) begin
              cnt_q    <= '0;
              map_m2_q <= 1'b0;
              state_q  <= WR_LO;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
          WR_LO: begin
            // sst_we_reg stayed high through the m2 fall for hold time.
            sst_we_reg_q <= 1'b0;
            if (idx_q == LAST_IDX) begin
              state_q <= FIN;
            end else begin
              idx_q       <= idx_q + 8'd1;
              dat_i_rdy_q <= 1'b1;
              state_q     <= WR_GET;
            end
          end
          FIN: begin
            sst_act_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign dat_o      = dat_o_q;
  assign dat_o_vld  = dat_o_vld_q;
  assign dat_i_rdy  = dat_i_rdy_q;
  assign sst_act    = sst_act_q;
  assign sst_addr   = sst_addr_q;
  assign sst_dato   = sst_dato_q;
  assign sst_we_reg = sst_we_reg_q;
  assign map_m2     = map_m2_q;

endmodule

// File: tb/tb_map_sst_seq.sv
module tb_map_sst_seq;
  localparam int unsigned RC = 4;
  localparam int unsigned ST = 2;
  localparam int unsigned MH = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, dir = 1'b0, abort = 1'b0;
  logic       busy, done, aborted;
  logic [7:0] dat_o;
  logic       dat_o_vld;
  logic       dat_o_rdy = 1'b0;
  logic [7:0] dat_i = '0;
  logic       dat_i_vld = 1'b0;
  logic       dat_i_rdy;
  logic       sst_act;
  logic [7:0] sst_addr, sst_dato;
  logic       sst_we_reg;
  logic [7:0] sst_di;
  logic       map_m2;

  map_sst_seq #(.REG_CNT(RC), .SETTLE(ST), .M2_HI(MH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .abort(abort),
    .busy(busy), .done(done), .aborted(aborted),
    .dat_o(dat_o), .dat_o_vld(dat_o_vld), .dat_o_rdy(dat_o_rdy),
    .dat_i(dat_i), .dat_i_vld(dat_i_vld), .dat_i_rdy(dat_i_rdy),
    .sst_act(sst_act), .sst_addr(sst_addr), .sst_dato(sst_dato),
    .sst_we_reg(sst_we_reg), .sst_di(sst_di), .map_m2(map_m2)
  );

  always #5 clk = ~clk;

  // Mapper model: readable register file and write-captured register file.
  logic [7:0] di_mem  [256];
  logic [7:0] map_reg [256];
  logic [7:0] exp_reg [256];
  assign sst_di = di_mem[sst_addr];

  typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
  logic [7:0] save_q [$];
  wr_t        wr_q   [$];
  wr_t        e;
  logic [7:0] ld [RC];

  int n_pass = 0, n_chk = 0;
  int done_cnt = 0, abort_cnt = 0, fall_cnt = 0, act_viol = 0;
  int hi_cnt = 0;
  logic prev_m2 = 1'b0;
  logic stall_prev = 1'b0;
  logic [7:0] stall_dat, stall_addr;
  bit rdy_rand = 1'b0;
  int stall_left = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", nm, act, exp);
  endtask

  // Monitor: save scoreboard, stall stability, mapper commits, pulse counters.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_m2    = 1'b0;
      hi_cnt     = 0;
      stall_prev = 1'b0;
    end else begin
      if (busy !== sst_act) act_viol++;
      if (done) done_cnt++;
      if (aborted) abort_cnt++;
      if (dat_o_vld && dat_o_rdy) begin
        if (save_q.size() == 0) chk("save_extra_byte", 1, 0);
        else chk("save_byte", dat_o, save_q.pop_front());
      end
      if (stall_prev && dat_o_vld) begin
        chk("stall_dat_o", dat_o, stall_dat);
        chk("stall_sst_addr", sst_addr, stall_addr);
      end
      stall_prev = dat_o_vld && !dat_o_rdy;
      stall_dat  = dat_o;
      stall_addr = sst_addr;
      if (prev_m2 && !map_m2) begin
        fall_cnt++;
        if (sst_we_reg) begin
          map_reg[sst_addr] = sst_dato;
          chk("m2_high_len", hi_cnt, MH);
          if (wr_q.size() == 0) chk("commit_extra", 1, 0);
          else begin
            e = wr_q.pop_front();
            chk("commit_addr", sst_addr, e.a);
            chk("commit_data", sst_dato, e.d);
          end
        end
      end
      if (map_m2) hi_cnt++;
      else hi_cnt = 0;
      prev_m2 = map_m2;
    end
  end

  // Host ready driver for the save stream.
  initial forever begin
    @(posedge clk); #1;
    if (stall_left > 0 && dat_o_vld && sst_addr == 8'd2) begin
      dat_o_rdy = 1'b0;
      stall_left--;
    end else begin
      dat_o_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic d, input logic ab);
    start = 1'b1; dir = d; abort = ab;
    tick();
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (done || aborted) break;
      n++;
      if (n > budget) begin
        chk("end_timeout", 0, 1);
        break;
      end
    end
    tick();
  endtask

  task automatic send_byte(input logic [7:0] d, input int idx);
    int n;
    bit ok;
    n = 0; ok = 1'b1;
    dat_i = d; dat_i_vld = 1'b1;
    forever begin
      @(negedge clk);
      if (dat_i_rdy) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 0, 1);
        ok = 1'b0;
        break;
      end
    end
    if (ok) begin
      wr_q.push_back('{a: 8'(idx), d: d});
      exp_reg[idx] = d;
    end
    tick();
    dat_i_vld = 1'b0;
  endtask

  task automatic run_save();
    for (int i = 0; i < int'(RC); i++) save_q.push_back(di_mem[i]);
    do_start(1'b0, 1'b0);
    wait_end(300);
  endtask

  task automatic run_load(input int gap);
    do_start(1'b1, 1'b0);
    for (int i = 0; i < int'(RC); i++) begin
      repeat ((gap < 0) ? $urandom_range(0, 3) : gap) tick();
      send_byte(ld[i], i);
    end
    wait_end(300);
  endtask

  task automatic chk_regs(input string nm);
    for (int i = 0; i < int'(RC); i++) chk(nm, map_reg[i], exp_reg[i]);
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_ctrl"}, {busy, done, aborted, dat_o_vld, dat_i_rdy, sst_act, sst_we_reg, map_m2}, 0);
    chk({nm, "_data"}, {dat_o, sst_addr, sst_dato}, 0);
  endtask

  int d0, f0, a0;
  logic [7:0] keep;

  initial begin
    for (int i = 0; i < 256; i++) begin
      di_mem[i]  = 8'hA0 + 8'(i);
      map_reg[i] = '0;
      exp_reg[i] = '0;
    end
    #12;
    chk_reset_outs("reset");
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Save with the A0+addr register model.
    d0 = done_cnt; f0 = fall_cnt;
    for (int i = 0; i < int'(RC); i++) save_q.push_back(di_mem[i]);
    do_start(1'b0, 1'b0);
    chk("busy_after_start", busy, 1);
    chk("act_after_start", sst_act, 1);
    wait_end(300);
    chk("save1_all_bytes", save_q.size(), 0);
    chk("save1_done_once", done_cnt - d0, 1);
    chk("save1_no_m2", fall_cnt - f0, 0);
    chk("save1_idle", {busy, sst_act}, 0);

    // Load 11,22,33,44 with 3-cycle valid gaps.
    d0 = done_cnt; f0 = fall_cnt;
    ld[0] = 8'h11; ld[1] = 8'h22; ld[2] = 8'h33; ld[3] = 8'h44;
    run_load(3);
    repeat (2) tick();
    chk("load1_falls", fall_cnt - f0, RC);
    chk("load1_done_once", done_cnt - d0, 1);
    chk("load1_all_commits", wr_q.size(), 0);
    chk_regs("load1_reg");

    // Save with a 5-cycle host stall on byte 2.
    d0 = done_cnt;
    for (int i = 0; i < int'(RC); i++) di_mem[i] = 8'($urandom);
    stall_left = 5;
    run_save();
    chk("stall_used", stall_left, 0);
    chk("save2_all_bytes", save_q.size(), 0);
    chk("save2_done_once", done_cnt - d0, 1);

    // Abort during WR_HI of register 1.
    d0 = done_cnt; a0 = abort_cnt;
    keep = exp_reg[1];
    do_start(1'b1, 1'b0);
    send_byte(8'h55, 0);
    send_byte(8'h99, 1);
    chk("abort_in_wr_hi", map_m2, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_pulse", aborted, 1);
    chk("abort_outs", {busy, sst_act, sst_we_reg, map_m2, dat_o_vld, dat_i_rdy, done}, 0);
    void'(wr_q.pop_back());
    exp_reg[1] = keep;
    repeat (3) tick();
    chk("abort_reg0", map_reg[0], 8'h55);
    chk("abort_reg1", map_reg[1], keep);
    chk("abort_once", abort_cnt - a0, 1);
    chk("abort_no_done", done_cnt - d0, 0);

    // start pulsed while busy is ignored.
    d0 = done_cnt; f0 = fall_cnt;
    for (int i = 0; i < int'(RC); i++) save_q.push_back(di_mem[i]);
    do_start(1'b0, 1'b0);
    tick(); tick();
    do_start(1'b1, 1'b0);
    wait_end(300);
    chk("restart_ignored_bytes", save_q.size(), 0);
    chk("restart_ignored_done", done_cnt - d0, 1);
    chk("restart_ignored_no_m2", fall_cnt - f0, 0);

    // start and abort together in IDLE: start wins.
    d0 = done_cnt; a0 = abort_cnt;
    for (int i = 0; i < int'(RC); i++) save_q.push_back(di_mem[i]);
    do_start(1'b0, 1'b1);
    chk("start_abort_busy", busy, 1);
    chk("start_abort_no_pulse", aborted, 0);
    wait_end(300);
    chk("start_abort_bytes", save_q.size(), 0);
    chk("start_abort_done", done_cnt - d0, 1);
    chk("start_abort_no_abort", abort_cnt - a0, 0);

    // Reset mid-load with map_m2 high.
    d0 = done_cnt; a0 = abort_cnt;
    keep = exp_reg[0];
    do_start(1'b1, 1'b0);
    send_byte(8'h77, 0);
    chk("pre_reset_m2", map_m2, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("async_reset");
    wr_q.delete();
    save_q.delete();
    exp_reg[0] = keep;
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("reset_no_pulses", (done_cnt - d0) + (abort_cnt - a0), 0);
    chk("reset_reg0", map_reg[0], keep);
    d0 = done_cnt;
    for (int i = 0; i < int'(RC); i++) di_mem[i] = 8'($urandom);
    run_save();
    chk("post_reset_bytes", save_q.size(), 0);
    chk("post_reset_done", done_cnt - d0, 1);

    // Randomized transfers with random host ready and valid gaps.
    rdy_rand = 1'b1;
    for (int it = 0; it < 8; it++) begin
      d0 = done_cnt;
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < int'(RC); i++) di_mem[i] = 8'($urandom);
        run_save();
        chk("rnd_save_bytes", save_q.size(), 0);
      end else begin
        for (int i = 0; i < int'(RC); i++) ld[i] = 8'($urandom);
        run_load(-1);
        repeat (2) tick();
        chk("rnd_load_commits", wr_q.size(), 0);
        chk_regs("rnd_load_reg");
      end
      chk("rnd_done_once", done_cnt - d0, 1);
    end

    chk("busy_matches_act", act_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
